// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared cache definitions: default geometry of the tag store,
//               FSM state encoding for the tag-store sequencer, and a
//               one-hot to binary index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Default tag-store geometry
  localparam int c_cache_ways  = 4;
  localparam int c_cache_sets  = 8;
  localparam int c_cache_tag_w = 24;

  // Tag-store sequencer states
  localparam int         c_state_w  = 1;
  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_clear = 1'b1;

  // Index of the lowest set bit of a one-hot vector (up to 8 ways).
  // Returns 0 for an all-zero input.
  function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 7; i >= 0; i--) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lru_age_update.sv
`default_nettype none
// ============================================================================
// Module      : lru_age_update
// Description : Combinational true-LRU age update for one set. The accessed
//               way becomes age 0, ways younger than the accessed way's old
//               age get one older, all others keep their age. An all-zero
//               access vector leaves every age unchanged.
// Ports       : i_ages   - current packed ages, way w at [w*AGE_W +: AGE_W]
//               i_access - one-hot accessed way
//               o_ages   - next packed ages
// Revision    : 1.0 - initial release
// ============================================================================
module lru_age_update #(
  parameter int WAYS  = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS*AGE_W-1:0] i_ages,
  input  logic [WAYS-1:0]       i_access,
  output logic [WAYS*AGE_W-1:0] o_ages
);

  // Old age of the accessed way (OR-select, access is one-hot)
  logic [AGE_W-1:0] w_old_age;

  always_comb begin
    w_old_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (i_access[w]) w_old_age = w_old_age | i_ages[w*AGE_W +: AGE_W];
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [AGE_W-1:0] w_age;
    assign w_age = i_ages[w*AGE_W +: AGE_W];
    assign o_ages[w*AGE_W +: AGE_W] = i_access[w]          ? '0 :
                                      (w_age < w_old_age)  ? w_age + AGE_W'(1) :
                                                             w_age;
  end

endmodule
`default_nettype wire

// File: rtl/tag_array_nway.sv
`default_nettype none
// ============================================================================
// Module      : tag_array_nway
// Description : N-way set-associative tag store with registered lookup, hit
//               detection, true-LRU victim selection, refill and dirty-mark
//               writes, and an invalidate-all sequencer (one set per cycle).
// Ports       : clk/resetn          - clock, async active-low reset
//               ready               - idle, requests accepted only when high
//               lookup_*            - lookup request (set, tag)
//               resp_valid, hit, hit_way, victim_* - registered lookup result
//               refill_*            - tag write to one way of a set
//               mark_dirty_en, mark_* - set dirty bit of one way
//               inv_all             - invalidate-all pulse
// Config      : TAG_ARRAY_DIRTY_EN  - when defined, dirty bits are stored;
//               otherwise victim_dirty is 0 and dirty inputs are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_array_nway
  import cache_pkg::*;
#(
  parameter int WAYS  = c_cache_ways,
  parameter int SETS  = c_cache_sets,
  parameter int TAG_W = c_cache_tag_w,
  parameter int IDX_W = $clog2(SETS),
  parameter int AGE_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             ready,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             resp_valid,
  output logic             hit,
  output logic [WAYS-1:0]  hit_way,
  output logic [WAYS-1:0]  victim_way,
  output logic             victim_valid,
  output logic             victim_dirty,
  output logic [TAG_W-1:0] victim_tag,
  input  logic             refill_en,
  input  logic [IDX_W-1:0] refill_idx,
  input  logic [WAYS-1:0]  refill_way,
  input  logic [TAG_W-1:0] refill_tag,
  input  logic             refill_dirty,
  input  logic             mark_dirty_en,
  input  logic [IDX_W-1:0] mark_idx,
  input  logic [WAYS-1:0]  mark_way,
  input  logic             inv_all
);

  function automatic logic [WAYS*AGE_W-1:0] f_age_init();
    logic [WAYS*AGE_W-1:0] a;
    for (int w = 0; w < WAYS; w++) a[w*AGE_W +: AGE_W] = AGE_W'(w);
    return a;
  endfunction

  // Cleared set: way w gets age w, so way WAYS-1 is the first LRU victim
  localparam logic [WAYS*AGE_W-1:0] c_age_init = f_age_init();

  // Storage
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAYS*AGE_W-1:0] r_age   [SETS];

  logic [c_state_w-1:0]  r_state;
  logic [IDX_W-1:0]      r_clr_cnt;

  logic                  r_resp_valid, r_hit, r_victim_valid, r_victim_dirty;
  logic [WAYS-1:0]       r_hit_way, r_victim_way;
  logic [TAG_W-1:0]      r_victim_tag;

  logic                  w_ready, w_lookup_acc, w_refill_acc, w_hit, w_found;
  logic [WAYS-1:0]       w_match, w_victim, w_set_valid;
  logic [WAYS*AGE_W-1:0] w_set_age, w_lookup_age, w_refill_age;
  logic [AGE_W-1:0]      w_victim_idx;
  logic                  w_victim_dirty;

  assign w_ready      = (r_state == c_st_idle);
  assign w_lookup_acc = w_ready && lookup_valid;
  assign w_refill_acc = w_ready && refill_en;

  assign w_set_valid  = r_valid[lookup_idx];
  assign w_set_age    = r_age[lookup_idx];

  for (genvar w = 0; w < WAYS; w++) begin : g_match
    assign w_match[w] = w_set_valid[w] && (r_tag[lookup_idx][w] == lookup_tag);
  end
  assign w_hit = |w_match;

  // Victim: lowest invalid way, else the oldest way
  always_comb begin
    w_victim = '0;
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_set_valid[w] && !w_found) begin
        w_victim[w] = 1'b1;
        w_found     = 1'b1;
      end
    end
    if (!w_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w_set_age[w*AGE_W +: AGE_W] == AGE_W'(WAYS-1)) w_victim[w] = 1'b1;
      end
    end
  end

  assign w_victim_idx = AGE_W'(onehot_to_idx(8'(w_victim)));

  lru_age_update #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru_lookup (
    .i_ages   (w_set_age),
    .i_access (w_match),
    .o_ages   (w_lookup_age)
  );

  lru_age_update #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru_refill (
    .i_ages   (r_age[refill_idx]),
    .i_access (refill_way),
    .o_ages   (w_refill_age)
  );

`ifdef TAG_ARRAY_DIRTY_EN
  logic [WAYS-1:0] r_dirty [SETS];
  logic            w_mark_acc;
  logic [WAYS-1:0] w_refill_dirty;

  assign w_mark_acc     = w_ready && mark_dirty_en;
  assign w_victim_dirty = |(r_dirty[lookup_idx] & w_victim & w_set_valid);

  // Refill set's dirty vector, folding in a mark to the same set so that
  // a mark of the way being refilled still lands.
  assign w_refill_dirty = (r_dirty[refill_idx] & ~refill_way)
                        | ({WAYS{refill_dirty}} & refill_way)
                        | ((w_mark_acc && (mark_idx == refill_idx))
                           ? (mark_way & (r_valid[refill_idx] | refill_way)) : '0);

  always_ff @(posedge clk) begin
    if (r_state == c_st_clear) begin
      r_dirty[r_clr_cnt] <= '0;
    end else begin
      if (w_refill_acc) r_dirty[refill_idx] <= w_refill_dirty;
      if (w_mark_acc && !(w_refill_acc && (mark_idx == refill_idx)))
        r_dirty[mark_idx] <= r_dirty[mark_idx] | (mark_way & r_valid[mark_idx]);
    end
  end
`else
  logic w_unused_dirty;
  assign w_unused_dirty = ^{refill_dirty, mark_dirty_en, mark_idx, mark_way};
  assign w_victim_dirty = 1'b0;
`endif

  // Sequencer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= c_st_clear;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (inv_all) begin
            r_state   <= c_st_clear;
            r_clr_cnt <= '0;
          end
        end
        default: begin
          r_clr_cnt <= r_clr_cnt + IDX_W'(1);
          if (r_clr_cnt == IDX_W'(SETS-1)) r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Tag/valid/age storage. Refill owns the age update when it targets the
  // same set as a hitting lookup.
  always_ff @(posedge clk) begin
    if (r_state == c_st_clear) begin
      r_valid[r_clr_cnt] <= '0;
      r_age[r_clr_cnt]   <= c_age_init;
    end else begin
      if (w_refill_acc) begin
        for (int w = 0; w < WAYS; w++) begin
          if (refill_way[w]) r_tag[refill_idx][w] <= refill_tag;
        end
        r_valid[refill_idx] <= r_valid[refill_idx] | refill_way;
        r_age[refill_idx]   <= w_refill_age;
      end
      if (w_lookup_acc && w_hit && !(w_refill_acc && (refill_idx == lookup_idx)))
        r_age[lookup_idx] <= w_lookup_age;
    end
  end

  // Registered lookup result, held until the next accepted lookup
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_valid   <= 1'b0;
      r_hit          <= 1'b0;
      r_hit_way      <= '0;
      r_victim_way   <= '0;
      r_victim_valid <= 1'b0;
      r_victim_dirty <= 1'b0;
      r_victim_tag   <= '0;
    end else begin
      r_resp_valid <= w_lookup_acc;
      if (w_lookup_acc) begin
        r_hit          <= w_hit;
        r_hit_way      <= w_match;
        r_victim_way   <= w_victim;
        r_victim_valid <= |(w_victim & w_set_valid);
        r_victim_dirty <= w_victim_dirty;
        r_victim_tag   <= r_tag[lookup_idx][w_victim_idx];
      end
    end
  end

  assign ready        = w_ready;
  assign resp_valid   = r_resp_valid;
  assign hit          = r_hit;
  assign hit_way      = r_hit_way;
  assign victim_way   = r_victim_way;
  assign victim_valid = r_victim_valid;
  assign victim_dirty = r_victim_dirty;
  assign victim_tag   = r_victim_tag;

endmodule
`default_nettype wire
